// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and default timing for button debouncers
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } db_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 50000;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous single-bit input
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - button synchroniser/debouncer with rise pulse; fall pulse under BTN_DEBOUNCE_FALL_PULSE_EN
module btn_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s_in;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_d;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
    logic             fall_d;
`endif

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOW;
            cnt_q      <= '0;
            db_level   <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level   <= (state_d == S_HIGH) || (state_d == S_FALL_CHK);
            rise_pulse <= rise_d;
        end
    end

`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= fall_d;
        end
    end
`else
    assign fall_pulse = 1'b0;
`endif

    // A CHK state returns to its stable state on any bounce; the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            S_LOW: begin
                if (s_in) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!s_in) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s_in) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = '0;
                end
            end
            S_FALL_CHK: begin
                if (s_in) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb/tb_btn_debounce_pulse.sv - scoreboard bench for btn_debounce_pulse; honours BTN_DEBOUNCE_FALL_PULSE_EN
module tb_btn_debounce_pulse;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int LAT  = SYNC + 1 + DB;

    typedef struct packed {
        logic lvl;
        logic rp;
        logic fp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic db_level, rise_pulse, fall_pulse;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic tff_q;
    logic any_rise, any_fall;

    btn_debounce_pulse #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    // Downstream T flip-flop toggled by rise_pulse.
    always @(posedge clk) tff_q <= rst ? 1'b0 : (tff_q ^ rise_pulse);

    // Reference: a level change is accepted once the synchronised input has
    // differed from the accepted level for DB+1 consecutive FSM samples.
    initial begin : model
        int   pipe[$];
        int   lvl, run, s;
        exp_t e;
        lvl = 0;
        run = 0;
        for (int i = 0; i < SYNC; i++) pipe.push_back(0);
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                pipe.delete();
                for (int i = 0; i < SYNC; i++) pipe.push_back(0);
                lvl = 0;
                run = 0;
            end else begin
                s = pipe.pop_front();
                pipe.push_back(int'(btn_in));
                run = (s != lvl) ? run + 1 : 0;
                if (run == DB + 1) begin
                    lvl = 1 - lvl;
                    run = 0;
                    if (lvl == 1) e.rp = 1'b1;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
                    else e.fp = 1'b1;
`endif
                end
            end
            e.lvl = logic'(lvl);
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({db_level, rise_pulse, fall_pulse} !== {e.lvl, e.rp, e.fp}) begin
                    errors++;
                    $display("FAIL outputs t=%0t got lvl/rise/fall=%b%b%b want %b%b%b",
                             $time, db_level, rise_pulse, fall_pulse, e.lvl, e.rp, e.fp);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic hold(input logic v, input int n);
        btn_in = v;
        repeat (n) begin
            @(negedge clk);
            any_rise |= rise_pulse;
            any_fall |= fall_pulse;
        end
    endtask

    // From a negedge: count posedges until the selected pulse appears.
    task automatic measure(input bit want_fall, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!(want_fall ? fall_pulse : rise_pulse) && n < 40);
        @(negedge clk);
    endtask

    initial begin : stim
        int n, toggles;
        logic prev_q;
        // Reset held with button pressed
        rst = 1'b1;
        btn_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({db_level, rise_pulse, fall_pulse}), 0);
        end
        rst = 1'b0;
        hold(1'b0, 10);

        // Clean press latency
        btn_in = 1'b1;
        measure(1'b0, n);
        check("rise_latency", n, LAT);
        check("db_level_after_rise", int'(db_level), 1);
        hold(1'b1, 5);

        // Release
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
        btn_in = 1'b0;
        measure(1'b1, n);
        check("fall_latency", n, LAT);
        check("db_level_after_fall", int'(db_level), 0);
        hold(1'b0, 5);
`else
        any_fall = 1'b0;
        hold(1'b0, 15);
        check("fall_pulse_disabled", int'(any_fall), 0);
        check("db_level_after_release", int'(db_level), 0);
`endif

        // Bounce never qualifies
        any_rise = 1'b0;
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 12);
        check("bounce_no_rise", int'(any_rise), 0);
        check("bounce_level", int'(db_level), 0);

        // Reset in the middle of qualification
        any_rise = 1'b0;
        hold(1'b1, 5);
        rst = 1'b1;
        hold(1'b1, 2);
        check("midchk_no_rise", int'(any_rise), 0);
        rst = 1'b0;
        measure(1'b0, n);
        check("post_reset_rise_latency", n, LAT);
        hold(1'b0, 15);

        // Three presses toggle the downstream T-FF three times
        toggles = 0;
        prev_q = tff_q;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 24; c++) begin
                btn_in = (c < 12);
                @(negedge clk);
                if (tff_q !== prev_q) toggles++;
                prev_q = tff_q;
            end
        end
        check("tff_toggles", toggles, 3);

        // Randomised runs, occasional reset
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                hold(logic'($urandom_range(0, 1)), $urandom_range(1, 2));
                rst = 1'b0;
            end
            hold(logic'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        hold(1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
